// File: rtl/decoder_pkg.sv
// Shared decoder/UART definitions: word type, UART bit-period base
// and the receiver FSM state type.
package decoder_pkg;

  typedef logic [31:0] word;

  localparam word UartCmpVal = 32'd16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin.
// Flops reset to 1 so an idle line is seen during and after reset.
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 4 bytes (LSB first) per 32-bit word, valid/ready out.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
  import decoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] prescaler,
  input  logic        rx,
  input  logic        ready,
  output logic [31:0] d_out,
  output logic        valid,
  output logic        framing_err,
  output logic        overrun
);

  logic rxs;

  uart_rx_sync u_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (rx),
    .q_o      (rxs)
  );

  uart_rx_state_t state_q, state_d;
  word            cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [1:0]     byte_q, byte_d;
  word            acc_q, acc_d;
  word            dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           h1_q;
  logic           samp;
  logic           done;
  word            per;
  word            half;
  word            new_word;

  assign per  = UartCmpVal << prescaler;
  assign half = per >> 1;

`ifdef UART_RX_MAJORITY_EN
  // Decisions run one cycle late so the sample+1 value is available;
  // counter reloads to 1 to keep the bit grid unshifted.
  localparam word Off = 32'd1;
  logic h2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) h2_q <= 1'b1;
    else           h2_q <= h1_q;
  end

  assign samp = (h2_q & h1_q) | (h2_q & rxs) | (h1_q & rxs);
`else
  localparam word Off = 32'd0;
  assign samp = rxs;
`endif

  assign new_word = acc_q | (word'(shift_q) << {byte_q, 3'b000});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    acc_d   = acc_q;
    ferr_d  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (h1_q && !rxs) state_d = START;
      end
      START: begin
        if (cnt_q == half + Off) begin
          if (samp) begin
            state_d = IDLE;
          end else begin
            cnt_d   = Off;
            bit_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == per - 32'd1 + Off) begin
          shift_d = {samp, shift_q[7:1]};
          cnt_d   = Off;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == per - 32'd1 + Off) begin
          if (samp) begin
            if (byte_q == 2'd3) begin
              done   = 1'b1;
              acc_d  = '0;
              byte_d = '0;
            end else begin
              acc_d  = new_word;
              byte_d = byte_q + 2'd1;
            end
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            acc_d   = '0;
            byte_d  = '0;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    ovr_d   = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || ready) begin
        dout_d  = new_word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      h1_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      h1_q    <= rxs;
    end
  end

  assign d_out       = dout_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule
